// File: rtl/expr_gen.sv
// -----------------------------------------------------------------------------
// expr_gen
// Stream source for the expression recogniser. A loaded list of single-digit
// operands and '+'/'*' operators is serialised as ASCII text of the form
// digit (op digit)*, one character per valid/ready transfer. Operand values
// of 10..15 are emitted as '#' so negative cases can be generated on purpose.
//
// Ports
//   clk       rising-edge clock
//   clr       synchronous active-high reset (aborts any stream in progress)
//   start     load request, accepted only while busy == 0
//   n_terms   operand count for the expression (clamped to MAX_TERMS)
//   digits    operand i in digits[4i+3:4i], operand 0 emitted first
//   ops       op i sits between operand i and i+1: 0 = '+', 1 = '*'
//   ch        ASCII character presented to the consumer
//   ch_valid  ch holds a character to transfer
//   ch_ready  consumer accepts; a transfer is ch_valid & ch_ready
//   busy      expression in progress, start is ignored
//   done      one-cycle pulse in the cycle after the final transfer
// -----------------------------------------------------------------------------
module expr_gen #(
  parameter int MAX_TERMS = 8,
  parameter int CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [CNT_W-1:0]       n_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             ch,
  output logic                   ch_valid,
  input  logic                   ch_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_OP    = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  // Operand value to ASCII; out-of-range values become '#'.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    logic [7:0] c;
    if (d <= 4'd9) begin
      c = 8'h30 + {4'h0, d};
    end else begin
      c = 8'h23;
    end
    return c;
  endfunction

  // Operator bit to ASCII: 0 -> '+', 1 -> '*'.
  function automatic logic [7:0] op_char(input logic op);
    return op ? 8'h2A : 8'h2B;
  endfunction

  // Control state (reset)
  state_t             state_q, state_d;
  logic               ch_valid_q, ch_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         ch_q, ch_d;

  // Captured expression (data, not reset)
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [4*MAX_TERMS-1:0] digits_q, digits_d;
  logic [MAX_TERMS-1:0]   ops_q, ops_d;

  logic                   xfer;
  logic [IDX_W-1:0]       nxt_idx;
  logic [CNT_W-1:0]       terms_clamp;

  assign xfer    = ch_valid_q & ch_ready;
  assign nxt_idx = idx_q + 1'b1;

  always_comb begin
    if (n_terms > CNT_W'(MAX_TERMS)) begin
      terms_clamp = CNT_W'(MAX_TERMS);
    end else begin
      terms_clamp = n_terms;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    ch_valid_d = ch_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    idx_d      = idx_q;
    last_d     = last_q;
    digits_d   = digits_q;
    ops_d      = ops_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          digits_d = digits;
          // Top bit pads the operator list so it can be indexed like digits.
          ops_d    = {1'b0, ops};
          idx_d    = '0;
          busy_d   = 1'b1;
          if (n_terms == '0) begin
            // Empty expression: no characters, straight to the done pulse.
            state_d    = S_FIN;
            ch_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            state_d    = S_DIGIT;
            last_d     = IDX_W'(terms_clamp - 1'b1);
            ch_d       = digit_char(digits[3:0]);
            ch_valid_d = 1'b1;
          end
        end
      end

      S_DIGIT: begin
        if (xfer) begin
          if (idx_q == last_q) begin
            state_d    = S_FIN;
            ch_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            state_d = S_OP;
            ch_d    = op_char(ops_q[idx_q]);
          end
        end
      end

      S_OP: begin
        if (xfer) begin
          state_d = S_DIGIT;
          idx_d   = nxt_idx;
          ch_d    = digit_char(digits_q[{nxt_idx, 2'b00} +: 4]);
        end
      end

      S_FIN: begin
        // start is ignored here because busy is still high this cycle.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d    = S_IDLE;
        ch_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Register stage: control state is reset, captured data is not.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      ch_q       <= 8'h00;
      ch_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      ch_valid_q <= ch_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
    idx_q    <= idx_d;
    last_q   <= last_d;
    digits_q <= digits_d;
    ops_q    <= ops_d;
  end

  assign ch       = ch_q;
  assign ch_valid = ch_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
